frame_writer: RTL and testbench

FRAME_WRITER -- requirements
Module: frame_writer

---
 rtl/frame_writer_if.sv | 51 +++++
 rtl/frame_writer.sv | 136 +++++++++++++
 tb/tb_frame_writer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_writer_if.sv
// Word-stream input and register-file write port of frame_writer.
// slave is the frame_writer side; master is the producer/consumer side.
interface frame_writer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] frame_0_out, frame_1_out;
  logic [31:0] frame_2_out, frame_3_out;
  logic [31:0] frame_4_out, frame_5_out;
  logic [31:0] frame_6_out, frame_7_out;
  logic [31:0] frame_8_out, frame_9_out;
  logic [31:0] frame_10_out, frame_11_out;
  logic [31:0] frame_12_out, frame_13_out;
  logic [31:0] frame_14_out, frame_15_out;
  logic        write;
  logic        Small_or_Big;
  logic        busy;
  logic        done;
  logic        frame_err;

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready,
    output frame_0_out, frame_1_out,
    output frame_2_out, frame_3_out,
    output frame_4_out, frame_5_out,
    output frame_6_out, frame_7_out,
    output frame_8_out, frame_9_out,
    output frame_10_out, frame_11_out,
    output frame_12_out, frame_13_out,
    output frame_14_out, frame_15_out,
    output write, Small_or_Big,
    output busy, done, frame_err
  );

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready,
    input  frame_0_out, frame_1_out,
    input  frame_2_out, frame_3_out,
    input  frame_4_out, frame_5_out,
    input  frame_6_out, frame_7_out,
    input  frame_8_out, frame_9_out,
    input  frame_10_out, frame_11_out,
    input  frame_12_out, frame_13_out,
    input  frame_14_out, frame_15_out,
    input  write, Small_or_Big,
    input  busy, done, frame_err
  );
endinterface

// File: rtl/frame_writer.sv
// Collects a 16-word frame, then writes it to a register file
// in two phases (column 0, then columns 1..3).
module frame_writer #(
  parameter int WR_HOLD = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  frame_writer_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, COLLECT, WR_LO, WR_HI, DONE
  } state_e;

  localparam logic [3:0] HOLD_MAX = 4'(WR_HOLD - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] frame_q [16];
  logic        write_q, write_d;
  logic        sob_q, sob_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept;
  logic        good_end;
  logic        bad_end;

  // rst_n gates in_ready so nothing is offered while held in reset
  assign bus.in_ready = rst_n &
    (state_q == IDLE || state_q == COLLECT);
  assign accept   = bus.in_valid & bus.in_ready;
  assign good_end = bus.in_last & (idx_q == 4'd15);
  assign bad_end  = bus.in_last ^ (idx_q == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      sob_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 16; i++) frame_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      sob_q   <= sob_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) frame_q[idx_q] <= bus.in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          unique case (1'b1)
            good_end: begin
              state_d = WR_LO;
              idx_d   = '0;
              cnt_d   = '0;
            end
            bad_end: begin
              state_d = IDLE;
              idx_d   = '0;
              err_d   = 1'b1;
            end
            default: begin
              state_d = COLLECT;
              idx_d   = idx_q + 4'd1;
            end
          endcase
        end
      end
      WR_LO: begin
        if (cnt_q == HOLD_MAX) begin
          state_d = WR_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_HI: begin
        if (cnt_q == HOLD_MAX) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // outputs are decoded from the next state and then registered
    write_d = (state_d == WR_LO) || (state_d == WR_HI);
    done_d  = (state_d == DONE);
    sob_d   = sob_q;
    if (state_d == WR_LO) sob_d = 1'b0;
    if (state_d == WR_HI) sob_d = 1'b1;
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.write        = write_q;
  assign bus.Small_or_Big = sob_q;
  assign bus.done         = done_q;
  assign bus.frame_err    = err_q;

  assign bus.frame_0_out  = frame_q[0];
  assign bus.frame_1_out  = frame_q[1];
  assign bus.frame_2_out  = frame_q[2];
  assign bus.frame_3_out  = frame_q[3];
  assign bus.frame_4_out  = frame_q[4];
  assign bus.frame_5_out  = frame_q[5];
  assign bus.frame_6_out  = frame_q[6];
  assign bus.frame_7_out  = frame_q[7];
  assign bus.frame_8_out  = frame_q[8];
  assign bus.frame_9_out  = frame_q[9];
  assign bus.frame_10_out = frame_q[10];
  assign bus.frame_11_out = frame_q[11];
  assign bus.frame_12_out = frame_q[12];
  assign bus.frame_13_out = frame_q[13];
  assign bus.frame_14_out = frame_q[14];
  assign bus.frame_15_out = frame_q[15];
endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: WR_HOLD=1 (dut_a)
// and WR_HOLD=3 (dut_b) sharing clock and reset.
module tb_frame_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_writer_if ifa ();
  frame_writer_if ifb ();

  frame_writer #(.WR_HOLD(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  frame_writer #(.WR_HOLD(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [511:0] fa, fb;
  assign fa = {ifa.frame_15_out, ifa.frame_14_out,
               ifa.frame_13_out, ifa.frame_12_out,
               ifa.frame_11_out, ifa.frame_10_out,
               ifa.frame_9_out,  ifa.frame_8_out,
               ifa.frame_7_out,  ifa.frame_6_out,
               ifa.frame_5_out,  ifa.frame_4_out,
               ifa.frame_3_out,  ifa.frame_2_out,
               ifa.frame_1_out,  ifa.frame_0_out};
  assign fb = {ifb.frame_15_out, ifb.frame_14_out,
               ifb.frame_13_out, ifb.frame_12_out,
               ifb.frame_11_out, ifb.frame_10_out,
               ifb.frame_9_out,  ifb.frame_8_out,
               ifb.frame_7_out,  ifb.frame_6_out,
               ifb.frame_5_out,  ifb.frame_4_out,
               ifb.frame_3_out,  ifb.frame_2_out,
               ifb.frame_1_out,  ifb.frame_0_out};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input bit v,
                       input logic [31:0] d, input bit l);
    if (w == 0) begin
      ifa.in_valid = v; ifa.in_data = d; ifa.in_last = l;
    end else begin
      ifb.in_valid = v; ifb.in_data = d; ifb.in_last = l;
    end
  endtask

  function automatic logic wr_of(input int w);
    return (w == 0) ? ifa.write : ifb.write;
  endfunction
  function automatic logic sob_of(input int w);
    return (w == 0) ? ifa.Small_or_Big : ifb.Small_or_Big;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 0) ? ifa.done : ifb.done;
  endfunction
  function automatic logic err_of(input int w);
    return (w == 0) ? ifa.frame_err : ifb.frame_err;
  endfunction
  function automatic logic rdy_of(input int w);
    return (w == 0) ? ifa.in_ready : ifb.in_ready;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? ifa.busy : ifb.busy;
  endfunction
  function automatic logic [31:0] frm(input int w, input int k);
    return (w == 0) ? fa[k*32 +: 32] : fb[k*32 +: 32];
  endfunction

  // Sends n words base+k; returns at the negedge after the last accept
  task automatic send_frame(input int w, input logic [31:0] base,
                            input int n, input bit last_end,
                            input bit gaps);
    int early = 0;
    for (int k = 0; k < n; k++) begin
      drive(w, 1'b1, base + k, last_end && (k == n - 1));
      @(negedge clk);
      if (k < n - 1) begin
        if (wr_of(w)) early++;
        if (gaps) begin
          drive(w, 1'b0, 32'h0, 1'b0);
          repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            if (wr_of(w)) early++;
          end
        end
      end
    end
    drive(w, 1'b0, 32'h0, 1'b0);
    check("no_early_write", early, 0);
  endtask

  // Write phases with junk offered on the input the whole time
  task automatic expect_write(input int w, input int hold);
    drive(w, 1'b1, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < hold; i++) begin
      check("lo_write", wr_of(w), 1'b1);
      check("lo_sob", sob_of(w), 1'b0);
      check("lo_ready", rdy_of(w), 1'b0);
      @(negedge clk);
    end
    for (int i = 0; i < hold; i++) begin
      check("hi_write", wr_of(w), 1'b1);
      check("hi_sob", sob_of(w), 1'b1);
      check("hi_busy", busy_of(w), 1'b1);
      @(negedge clk);
    end
    check("done_write", wr_of(w), 1'b0);
    check("done_pulse", done_of(w), 1'b1);
    check("done_sob_hold", sob_of(w), 1'b1);
    drive(w, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("done_clear", done_of(w), 1'b0);
    check("ready_again", rdy_of(w), 1'b1);
    check("busy_clear", busy_of(w), 1'b0);
  endtask

  task automatic check_frames(input int w, input logic [31:0] base);
    for (int k = 0; k < 16; k++)
      check($sformatf("frame_%0d", k), frm(w, k), base + k);
  endtask

  task automatic expect_err(input int w);
    check("err_pulse", err_of(w), 1'b1);
    check("err_no_write", wr_of(w), 1'b0);
    check("err_ready", rdy_of(w), 1'b1);
    check("err_idle", busy_of(w), 1'b0);
    @(negedge clk);
    check("err_clear", err_of(w), 1'b0);
    check("err_still_no_write", wr_of(w), 1'b0);
  endtask

  initial begin
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("rst_write", ifa.write, 1'b0);
    check("rst_sob", ifa.Small_or_Big, 1'b0);
    check("rst_ready", ifa.in_ready, 1'b0);
    check("rst_busy", ifa.busy, 1'b0);
    check("rst_done", ifa.done, 1'b0);
    check("rst_err", ifa.frame_err, 1'b0);
    check("rst_frame0", ifa.frame_0_out, 32'h0);
    check("rst_frame15", ifa.frame_15_out, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", ifa.in_ready, 1'b1);

    // Basic frame, words 0..15
    send_frame(0, 32'h0, 16, 1'b1, 1'b0);
    expect_write(0, 1);
    check_frames(0, 32'h0);

    // in_last on word 7: partial capture kept
    send_frame(0, 32'h700, 8, 1'b1, 1'b0);
    expect_err(0);
    check("part_f0", frm(0, 0), 32'h700);
    check("part_f7", frm(0, 7), 32'h707);
    check("part_f8", frm(0, 8), 32'h8);
    check("part_f15", frm(0, 15), 32'hF);

    // Gapped frame restarts at index 0
    send_frame(0, 32'h0, 16, 1'b1, 1'b1);
    expect_write(0, 1);
    check_frames(0, 32'h0);

    // 16th word without in_last
    send_frame(0, 32'h900, 16, 1'b0, 1'b0);
    expect_err(0);
    check("nolast_f15", frm(0, 15), 32'h90F);

    // WR_HOLD=3 instance
    send_frame(1, 32'h50, 16, 1'b1, 1'b0);
    expect_write(1, 3);
    check_frames(1, 32'h50);

    // Reset during WR_HI
    send_frame(0, 32'h20, 16, 1'b1, 1'b0);
    check("pre_lo_write", ifa.write, 1'b1);
    @(negedge clk);
    check("pre_hi_sob", ifa.Small_or_Big, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_write", ifa.write, 1'b0);
    check("async_sob", ifa.Small_or_Big, 1'b0);
    check("async_frame5", ifa.frame_5_out, 32'h0);
    check("async_frame15", ifa.frame_15_out, 32'h0);
    check("async_ready", ifa.in_ready, 1'b0);
    check("async_busy", ifa.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", ifa.in_ready, 1'b1);
    @(negedge clk);
    check("rel_ready2", ifa.in_ready, 1'b1);
    check("rel_write", ifa.write, 1'b0);
    check("rel_busy", ifa.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
